mem_stage_dcache: RTL

- MEM-stage data cache. Sits between the EX/MEM pipeline register and the MEM/WB register.
- Direct-mapped, one word per line, write-through, no-write-allocate.
- Drives the `hit` and `read_data` inputs of the MEM/WB register. `hit`=0 stalls the pipeline while a miss or write-through is serviced over a req/ack handshake to main memory.

---
 rtl/mem_stage_dcache.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_dcache.sv
// MEM-stage data cache: direct-mapped, one word per line, write-through, no-write-allocate.
// Optional read hit/miss counters are built when DCACHE_STATS_EN is defined.
module mem_stage_dcache #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        hit,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] read_hit_count,
  output logic [31:0] read_miss_count
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_r;
  logic [LINES-1:0]  valid_r;
  logic [TAG_W-1:0]  tag_r  [LINES];
  logic [31:0]       data_r [LINES];
  logic [31:0]       fill_r;
  logic              done_read_r;
  logic              mem_req_r;
  logic              mem_we_r;
  logic [31:0]       mem_addr_r;
  logic [31:0]       mem_wdata_r;

  logic [INDEX_BITS-1:0] index_s;
  logic [TAG_W-1:0]      tag_s;
  logic                  lookup_hit_s;
  logic                  read_hit_s;
  logic                  read_miss_s;
  logic                  fill_done_s;
  logic                  write_update_s;
  logic                  hit_s;
  logic [31:0]           read_data_s;
  logic                  unused_s;

  assign index_s        = address[INDEX_BITS+1:2];
  assign tag_s          = address[31:INDEX_BITS+2];
  assign unused_s       = ^address[1:0];
  assign lookup_hit_s   = valid_r[index_s] && (tag_r[index_s] == tag_s);
  assign read_hit_s     = (state_r == IDLE) && mem_read && !mem_write && lookup_hit_s;
  assign read_miss_s    = (state_r == IDLE) && mem_read && !mem_write && !lookup_hit_s;
  assign fill_done_s    = (state_r == FILL) && mem_ack;
  // Write-through updates only a resident line; a store never allocates.
  assign write_update_s = (state_r == WRITE) && mem_ack && lookup_hit_s;

  // Control FSM: state, valid bits, fill register and registered memory-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      valid_r     <= '0;
      fill_r      <= 32'h0;
      done_read_r <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'h0;
      mem_wdata_r <= 32'h0;
    end else begin
      case (state_r)
        IDLE: begin
          if (mem_write) begin
            state_r     <= WRITE;
            mem_req_r   <= 1'b1;
            mem_we_r    <= 1'b1;
            mem_addr_r  <= {address[31:2], 2'b00};
            mem_wdata_r <= write_data;
            done_read_r <= 1'b0;
          end else if (read_miss_s) begin
            state_r     <= FILL;
            mem_req_r   <= 1'b1;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {address[31:2], 2'b00};
            done_read_r <= 1'b1;
          end else begin
            state_r     <= IDLE;
          end
        end
        FILL: begin
          if (mem_ack) begin
            valid_r[index_s] <= 1'b1;
            fill_r           <= mem_rdata;
            mem_req_r        <= 1'b0;
            state_r          <= DONE;
          end
        end
        WRITE: begin
          if (mem_ack) begin
            mem_req_r <= 1'b0;
            mem_we_r  <= 1'b0;
            state_r   <= DONE;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r   <= IDLE;
          mem_req_r <= 1'b0;
          mem_we_r  <= 1'b0;
        end
      endcase
    end
  end

  // Line storage: tag/data need no reset since valid_r gates every lookup.
  always_ff @(posedge clk) begin
    if (fill_done_s) begin
      tag_r[index_s]  <= tag_s;
      data_r[index_s] <= mem_rdata;
    end else if (write_update_s) begin
      data_r[index_s] <= write_data;
    end
  end

  // Pipeline handshake: zero-latency hit in IDLE, one-cycle completion in DONE.
  always_comb begin
    hit_s       = 1'b1;
    read_data_s = 32'h0;
    if (rst) begin
      hit_s       = 1'b1;
      read_data_s = 32'h0;
    end else begin
      case (state_r)
        IDLE: begin
          if (mem_write) begin
            hit_s = 1'b0;
          end else if (mem_read) begin
            if (lookup_hit_s) begin
              read_data_s = data_r[index_s];
            end else begin
              hit_s = 1'b0;
            end
          end else begin
            hit_s = 1'b1;
          end
        end
        FILL, WRITE: begin
          hit_s = 1'b0;
        end
        DONE: begin
          if (done_read_r) begin
            read_data_s = fill_r;
          end else begin
            read_data_s = 32'h0;
          end
        end
        default: begin
          hit_s = 1'b1;
        end
      endcase
    end
  end

  assign hit       = hit_s;
  assign read_data = read_data_s;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

`ifdef DCACHE_STATS_EN
  logic [31:0] read_hit_cnt_r;
  logic [31:0] read_miss_cnt_r;

  // Read statistics, wrapping modulo 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_hit_cnt_r  <= 32'h0;
      read_miss_cnt_r <= 32'h0;
    end else begin
      if (read_hit_s) begin
        read_hit_cnt_r <= read_hit_cnt_r + 32'd1;
      end
      if (read_miss_s) begin
        read_miss_cnt_r <= read_miss_cnt_r + 32'd1;
      end
    end
  end

  assign read_hit_count  = read_hit_cnt_r;
  assign read_miss_count = read_miss_cnt_r;
`else
  assign read_hit_count  = 32'h0;
  assign read_miss_count = 32'h0;
`endif

endmodule
